// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instruction_fetch_unit_pkg;

  // Default bubble word: sll $zero,$zero,0
  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

  // Word index width into the 128-word instruction memory (address bits [8:2])
  localparam int IMEM_INDEX_W = 7;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pcplus4;
    logic        valid;
  } ifid_t;

  // An empty IF/ID slot: the NOP word with no PC and no valid flag.
  function automatic ifid_t makeBubble(input logic [31:0] nopWord);
    ifid_t b;
    b.instruction = nopWord;
    b.pcplus4     = 32'h0000_0000;
    b.valid       = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bus between the fetch unit (master) and the pipeline/memory side (slave).
interface instruction_fetch_unit_if;

  logic        Stall;
  logic        Flush;
  logic        PCSrc;
  logic [31:0] TargetAddress;
  logic        Halt;
  logic [31:0] Instruction;
  logic [31:0] InstrAddress;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic [31:0] FetchCount;
  logic        Halted;

  modport master (
    input  Stall, Flush, PCSrc, TargetAddress, Halt, Instruction,
    output InstrAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid,
           FetchCount, Halted
  );

  modport slave (
    output Stall, Flush, PCSrc, TargetAddress, Halt, Instruction,
    input  InstrAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid,
           FetchCount, Halted
  );

endinterface

// File: rtl/instruction_fetch_unit_pc_register.sv
// Program counter flop: loads nextPc_i when loadEn_i is high, else holds.
module instruction_fetch_unit_pc_register #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        loadEn_i,
  input  logic [31:0] nextPc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Select between holding the PC and taking the next-PC from the fetch FSM
  always_comb begin
    pc_d = pc_q;
    if (loadEn_i) begin
      pc_d = nextPc_i;
    end
  end

  // PC storage, returns to RESET_PC as soon as reset is asserted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC, fetch FSM, IF/ID register and fetch counter.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD   = DEFAULT_NOP_WORD,
  parameter int          IMEM_WORDS = 128
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  instruction_fetch_unit_if.master  bus
);

  // The memory aliases on a fixed 7-bit word index; other depths are not supported.
  if (IMEM_WORDS != (1 << IMEM_INDEX_W)) begin : g_depthCheck
    $error("instruction_fetch_unit: IMEM_WORDS must be %0d", 1 << IMEM_INDEX_W);
  end

  fetch_state_e state_q, state_d;
  ifid_t        ifid_q, ifid_d;
  logic [31:0]  fetchCount_q, fetchCount_d;

  logic [31:0]  pc;
  logic [31:0]  pcPlus4;
  logic [31:0]  pcNext;
  logic         pcLoad;
  logic [31:0]  alignedTarget;
  logic         unusedTargetLsbs;

  // Misaligned target bits are silently dropped.
  assign alignedTarget    = {bus.TargetAddress[31:2], 2'b00};
  assign unusedTargetLsbs = ^bus.TargetAddress[1:0];
  assign pcPlus4          = pc + 32'd4;

  instruction_fetch_unit_pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pcRegister (
    .clk_i    (Clk),
    .rst_ni   (Reset_n),
    .loadEn_i (pcLoad),
    .nextPc_i (pcNext),
    .pc_o     (pc)
  );

  // Fetch FSM: next state, PC update and IF/ID contents, Halt > PCSrc > Flush > Stall
  always_comb begin
    state_d      = state_q;
    ifid_d       = ifid_q;
    fetchCount_d = fetchCount_q;
    pcLoad       = 1'b0;
    pcNext       = pcPlus4;
    case (state_q)
      BOOT: begin
        state_d = bus.Halt ? HALTED : RUN;
      end
      RUN: begin
        if (bus.Halt) begin
          state_d = HALTED;
          ifid_d  = makeBubble(NOP_WORD);
        end else if (bus.PCSrc) begin
          pcLoad = 1'b1;
          pcNext = alignedTarget;
          ifid_d = makeBubble(NOP_WORD);
        end else if (bus.Flush) begin
          pcLoad = !bus.Stall;
          ifid_d = makeBubble(NOP_WORD);
        end else if (!bus.Stall) begin
          pcLoad             = 1'b1;
          ifid_d.instruction = bus.Instruction;
          ifid_d.pcplus4     = pcPlus4;
          ifid_d.valid       = 1'b1;
          fetchCount_d       = fetchCount_q + 32'd1;
        end
      end
      HALTED: begin
        ifid_d = makeBubble(NOP_WORD);
      end
      default: begin
        state_d = BOOT;
        ifid_d  = makeBubble(NOP_WORD);
      end
    endcase
  end

  // State, IF/ID and counter registers; reset clears any pending redirect
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= BOOT;
      ifid_q       <= makeBubble(NOP_WORD);
      fetchCount_q <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      ifid_q       <= ifid_d;
      fetchCount_q <= fetchCount_d;
    end
  end

  assign bus.InstrAddress     = pc;
  assign bus.IFID_Instruction = ifid_q.instruction;
  assign bus.IFID_PCPlus4     = ifid_q.pcplus4;
  assign bus.IFID_Valid       = ifid_q.valid;
  assign bus.FetchCount       = fetchCount_q;
  assign bus.Halted           = (state_q == HALTED);

endmodule
